// File: rtl/attn_pkg.sv
// Shared types and constants for the attention value stage (Z = S*V).
// Supplies default SRAM range macros when the integration does not define them.
`ifndef SRAM_ADDR_RANGE
`define SRAM_ADDR_RANGE 15:0
`endif
`ifndef SRAM_DATA_RANGE
`define SRAM_DATA_RANGE 31:0
`endif

package attn_pkg;

   localparam int ATTN_DIM_W  = 16;
   localparam int ATTN_DATA_W = 32;

   localparam logic [ATTN_DATA_W-1:0] ATTN_SAT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITE,
      DONE
   } attn_state_e;

endpackage

// File: rtl/attn_mac.sv
// Multiply-accumulate for one Z element; clear has priority over enable.
// ATTN_SATURATE_EN selects full-width products with a clamp at all-ones.
module attn_mac
   import attn_pkg::*;
#(
   parameter int W = ATTN_DATA_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] acc_d
);

   logic [W-1:0] acc;
   logic [W-1:0] sum_w;

`ifdef ATTN_SATURATE_EN
   logic [2*W-1:0] prod;
   logic [2*W:0]   sum;

   assign prod  = (2*W)'(a) * (2*W)'(b);
   assign sum   = {1'b0, prod} + (2*W+1)'(acc);
   // Once clamped, further non-negative terms keep it clamped.
   assign sum_w = (sum > (2*W+1)'(ATTN_SAT_MAX)) ? ATTN_SAT_MAX : sum[W-1:0];
`else
   assign sum_w = acc + a * b;
`endif

   always_comb begin
      acc_d = acc;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum_w;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else begin
         acc <= acc_d;
      end
   end

endmodule

// File: rtl/attention_value_stage.sv
// Computes Z = S*V one MAC per cycle, reading S/V from SRAM and writing Z row-major.
// Optional macro ATTN_SATURATE_EN (in attn_mac) clamps the accumulator instead of wrapping.
//
// state | meaning
// IDLE  | ready; accept latches dims/bases
// ISSUE | present S/V read addresses for current k
// DRAIN | accumulate the last product of the element
// WRITE | write Z[i][j], clear accumulator, advance j/i
// DONE  | one-cycle done pulse
module attention_value_stage
   import attn_pkg::*;
#(
   parameter int DIM_W  = ATTN_DIM_W,
   parameter int DATA_W = ATTN_DATA_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start_valid,
   output logic                    ready,
   output logic                    done,
   input  logic [DIM_W-1:0]        n_tokens,
   input  logic [DIM_W-1:0]        d_model,
   input  logic [`SRAM_ADDR_RANGE] s_base,
   input  logic [`SRAM_ADDR_RANGE] v_base,
   input  logic [`SRAM_ADDR_RANGE] z_base,
   output logic [`SRAM_ADDR_RANGE] dut__tb__sram_result_read_address,
   input  logic [`SRAM_DATA_RANGE] tb__dut__sram_result_read_data,
   output logic [`SRAM_ADDR_RANGE] dut__tb__sram_scratchpad_read_address,
   input  logic [`SRAM_DATA_RANGE] tb__dut__sram_scratchpad_read_data,
   output logic                    dut__tb__sram_result_write_enable,
   output logic [`SRAM_ADDR_RANGE] dut__tb__sram_result_write_address,
   output logic [`SRAM_DATA_RANGE] dut__tb__sram_result_write_data
);

   typedef logic [`SRAM_ADDR_RANGE] addr_t;

   attn_state_e state_q, state_d;

   logic [DIM_W-1:0] n_q, d_q;
   logic [DIM_W-1:0] k_left, j_left, i_left;
   addr_t            v_base_q;
   addr_t            s_row_q, s_ptr_q, v_col_q, v_ptr_q, z_ptr_q;
   addr_t            rd_s_hold, rd_v_hold, wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [DATA_W-1:0] acc_d;
   logic             valid_q;
   logic             accept;

   assign accept = (state_q == IDLE) && start_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_valid) state_d = (n_tokens == '0 || d_model == '0) ? DONE : ISSUE;
         ISSUE:   if (k_left == '0) state_d = DRAIN;
         DRAIN:   state_d = WRITE;
         WRITE:   state_d = (i_left == '0 && j_left == '0) ? DONE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pointers advance incrementally so no multiplier is needed for i*N or k*D.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q       <= '0;
         d_q       <= '0;
         k_left    <= '0;
         j_left    <= '0;
         i_left    <= '0;
         v_base_q  <= '0;
         s_row_q   <= '0;
         s_ptr_q   <= '0;
         v_col_q   <= '0;
         v_ptr_q   <= '0;
         z_ptr_q   <= '0;
         rd_s_hold <= '0;
         rd_v_hold <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= (state_q == ISSUE);
         unique case (state_q)
            IDLE: begin
               if (start_valid) begin
                  n_q      <= n_tokens;
                  d_q      <= d_model;
                  v_base_q <= v_base;
                  s_row_q  <= s_base;
                  s_ptr_q  <= s_base;
                  v_col_q  <= v_base;
                  v_ptr_q  <= v_base;
                  z_ptr_q  <= z_base;
                  k_left   <= n_tokens - 1'b1;
                  j_left   <= d_model - 1'b1;
                  i_left   <= n_tokens - 1'b1;
               end
            end
            ISSUE: begin
               rd_s_hold <= s_ptr_q;
               rd_v_hold <= v_ptr_q;
               s_ptr_q   <= s_ptr_q + 1'b1;
               v_ptr_q   <= v_ptr_q + addr_t'(d_q);
               if (k_left != '0) k_left <= k_left - 1'b1;
            end
            DRAIN: begin
               wr_addr_q <= z_ptr_q;
               wr_data_q <= acc_d;
            end
            WRITE: begin
               z_ptr_q <= z_ptr_q + 1'b1;
               k_left  <= n_q - 1'b1;
               if (j_left == '0) begin
                  j_left  <= d_q - 1'b1;
                  i_left  <= i_left - 1'b1;
                  s_row_q <= s_row_q + addr_t'(n_q);
                  s_ptr_q <= s_row_q + addr_t'(n_q);
                  v_col_q <= v_base_q;
                  v_ptr_q <= v_base_q;
               end else begin
                  j_left  <= j_left - 1'b1;
                  s_ptr_q <= s_row_q;
                  v_col_q <= v_col_q + 1'b1;
                  v_ptr_q <= v_col_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   attn_mac #(
      .W (DATA_W)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept || (state_q == WRITE)),
      .en      (valid_q),
      .a       (tb__dut__sram_result_read_data),
      .b       (tb__dut__sram_scratchpad_read_data),
      .acc_d   (acc_d)
   );

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);

   assign dut__tb__sram_result_read_address     = (state_q == ISSUE) ? s_ptr_q : rd_s_hold;
   assign dut__tb__sram_scratchpad_read_address = (state_q == ISSUE) ? v_ptr_q : rd_v_hold;

   assign dut__tb__sram_result_write_enable  = (state_q == WRITE);
   assign dut__tb__sram_result_write_address = wr_addr_q;
   assign dut__tb__sram_result_write_data    = wr_data_q;

endmodule

// File: tb/tb_attention_value_stage.sv
// Self-checking bench for attention_value_stage: table vectors, corner sequences, random jobs.
`ifndef SRAM_ADDR_RANGE
`define SRAM_ADDR_RANGE 15:0
`endif
`ifndef SRAM_DATA_RANGE
`define SRAM_DATA_RANGE 31:0
`endif

module tb_attention_value_stage;

   localparam int MAXN = 4;

`ifdef ATTN_SATURATE_EN
   localparam logic [31:0] OV0 = 32'hFFFF_FFFF;
   localparam logic [31:0] OV1 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OV0 = 32'd1;
   localparam logic [31:0] OV1 = 32'd2;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic                    start_valid = 1'b0;
   logic                    ready, done;
   logic [15:0]             n_tokens = '0, d_model = '0;
   logic [`SRAM_ADDR_RANGE] s_base = '0, v_base = '0, z_base = '0;
   logic [`SRAM_ADDR_RANGE] rd_addr_s, rd_addr_v, waddr;
   logic [`SRAM_DATA_RANGE] res_rd, spd_rd, wdata;
   logic                    we;

   attention_value_stage dut (
      .clk                                   (clk),
      .reset_n                               (reset_n),
      .start_valid                           (start_valid),
      .ready                                 (ready),
      .done                                  (done),
      .n_tokens                              (n_tokens),
      .d_model                               (d_model),
      .s_base                                (s_base),
      .v_base                                (v_base),
      .z_base                                (z_base),
      .dut__tb__sram_result_read_address     (rd_addr_s),
      .tb__dut__sram_result_read_data        (res_rd),
      .dut__tb__sram_scratchpad_read_address (rd_addr_v),
      .tb__dut__sram_scratchpad_read_data    (spd_rd),
      .dut__tb__sram_result_write_enable     (we),
      .dut__tb__sram_result_write_address    (waddr),
      .dut__tb__sram_result_write_data       (wdata)
   );

   logic [31:0] res_mem [0:65535];
   logic [31:0] spd_mem [0:65535];
   logic [47:0] wr_q[$];
   logic [47:0] exp_q[$];
   int          wr_start = 0;

   always @(posedge clk) begin
      res_rd <= res_mem[rd_addr_s];
      spd_rd <= spd_mem[rd_addr_v];
      if (we) wr_q.push_back({waddr, wdata});
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string             name;
      int                n;
      int                d;
      logic [15:0]       sb, vb, zb;
      logic [0:8][31:0]  s;
      logic [0:5][31:0]  v;
      logic [0:5][31:0]  z;
   } vec_t;

   vec_t        tbl [3];
   logic [31:0] s_mat [MAXN][MAXN];
   logic [31:0] v_mat [MAXN][MAXN];

   task automatic mats_from_vec(input int t);
      for (int i = 0; i < tbl[t].n; i++)
         for (int k = 0; k < tbl[t].n; k++) s_mat[i][k] = tbl[t].s[i*tbl[t].n+k];
      for (int k = 0; k < tbl[t].n; k++)
         for (int j = 0; j < tbl[t].d; j++) v_mat[k][j] = tbl[t].v[k*tbl[t].d+j];
   endtask

   task automatic load_mem(input int n, input int d, input logic [15:0] sb, input logic [15:0] vb);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < n; k++) res_mem[16'(int'(sb) + i*n + k)] = s_mat[i][k];
      for (int k = 0; k < n; k++)
         for (int j = 0; j < d; j++) spd_mem[16'(int'(vb) + k*d + j)] = v_mat[k][j];
   endtask

   // Reference: plain matrix product in 64-bit, reduced per the configured arithmetic.
   task automatic build_expect(input int n, input int d, input logic [15:0] zb);
      logic [63:0] acc;
      exp_q.delete();
      for (int i = 0; i < n; i++)
         for (int j = 0; j < d; j++) begin
            acc = 64'd0;
            for (int k = 0; k < n; k++) begin
               acc = acc + 64'(s_mat[i][k]) * 64'(v_mat[k][j]);
`ifdef ATTN_SATURATE_EN
               if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
`endif
            end
            exp_q.push_back({16'(int'(zb) + i*d + j), acc[31:0]});
         end
   endtask

   task automatic start_job(input int n, input int d, input logic [15:0] sb,
                            input logic [15:0] vb, input logic [15:0] zb, input bit hold);
      @(negedge clk);
      n_tokens = 16'(n); d_model = 16'(d);
      s_base = sb; v_base = vb; z_base = zb;
      start_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) start_valid = 1'b0;
   endtask

   // Called 1 time unit after the accept edge.
   task automatic run_to_end(input int n, input int d, input string name);
      int cyc, lim, done_at, done_cnt, got;
      lim = n*d*(n+2) + 1;
      cyc = 0; done_cnt = 0; done_at = -1;
      while (!ready && cyc < lim + 20) begin
         if (done) begin done_cnt++; done_at = cyc; end
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " ready_latency"}, cyc, lim);
      check({name, " done_count"}, done_cnt, 1);
      check({name, " done_cycle"}, done_at, lim - 1);
      got = wr_q.size() - wr_start;
      check({name, " write_count"}, got, exp_q.size());
      for (int e = 0; e < exp_q.size() && e < got; e++) begin
         check($sformatf("%s z%0d_addr", name, e), wr_q[wr_start+e][47:32], exp_q[e][47:32]);
         check($sformatf("%s z%0d_data", name, e), wr_q[wr_start+e][31:0], exp_q[e][31:0]);
      end
      wr_start = wr_q.size();
   endtask

   task automatic exp_from_table(input int t);
      exp_q.delete();
      for (int e = 0; e < tbl[t].n * tbl[t].d; e++)
         exp_q.push_back({16'(int'(tbl[t].zb) + e), tbl[t].z[e]});
   endtask

   initial begin
      tbl[0].name = "identity"; tbl[0].n = 2; tbl[0].d = 2;
      tbl[0].sb = 16'h0100; tbl[0].vb = 16'h0200; tbl[0].zb = 16'h0300;
      tbl[0].s = {32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      tbl[0].v = {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};
      tbl[0].z = {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};

      tbl[1].name = "general"; tbl[1].n = 3; tbl[1].d = 2;
      tbl[1].sb = 16'h1000; tbl[1].vb = 16'h1100; tbl[1].zb = 16'h1200;
      tbl[1].s = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
      tbl[1].v = {32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
      tbl[1].z = {32'd4, 32'd5, 32'd10, 32'd11, 32'd16, 32'd17};

      // Z base at the top of the address space: second write wraps to 0.
      tbl[2].name = "overflow"; tbl[2].n = 2; tbl[2].d = 1;
      tbl[2].sb = 16'h2000; tbl[2].vb = 16'h2100; tbl[2].zb = 16'hFFFF;
      tbl[2].s = {32'hFFFF_FFFF, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      tbl[2].v = {32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
      tbl[2].z = {OV0, OV1, 32'd0, 32'd0, 32'd0, 32'd0};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst ready", ready, 1'b1);
      check("rst done", done, 1'b0);
      check("rst we", we, 1'b0);
      check("rst rd_s", rd_addr_s, 16'h0);
      check("rst rd_v", rd_addr_v, 16'h0);
      check("rst waddr", waddr, 16'h0);
      check("rst wdata", wdata, 32'h0);
      @(negedge clk); reset_n = 1'b1;

      // Degenerate jobs: N=0, then D=0
      exp_q.delete();
      start_job(0, 3, 16'h0040, 16'h0050, 16'h0060, 1'b0);
      check("degen_n done", done, 1'b1);
      run_to_end(0, 3, "degen_n");
      @(posedge clk); #1;
      check("degen_n ready+2", ready, 1'b1);
      exp_q.delete();
      start_job(3, 0, 16'h0040, 16'h0050, 16'h0060, 1'b0);
      run_to_end(3, 0, "degen_d");
      check("degen rd_s", rd_addr_s, 16'h0);
      check("degen rd_v", rd_addr_v, 16'h0);

      // Table vectors
      for (int t = 0; t < 3; t++) begin
         mats_from_vec(t);
         load_mem(tbl[t].n, tbl[t].d, tbl[t].sb, tbl[t].vb);
         exp_from_table(t);
         start_job(tbl[t].n, tbl[t].d, tbl[t].sb, tbl[t].vb, tbl[t].zb, 1'b0);
         run_to_end(tbl[t].n, tbl[t].d, tbl[t].name);
      end

      // Reset during the 3rd ISSUE cycle, then rerun
      start_job(3, 2, tbl[1].sb, tbl[1].vb, tbl[1].zb, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("midrst we", we, 1'b0);
      check("midrst ready", ready, 1'b1);
      check("midrst done", done, 1'b0);
      check("midrst rd_s", rd_addr_s, 16'h0);
      @(negedge clk); reset_n = 1'b1;
      check("midrst no_write", wr_q.size() - wr_start, 0);
      wr_start = wr_q.size();
      exp_from_table(1);
      start_job(3, 2, tbl[1].sb, tbl[1].vb, tbl[1].zb, 1'b0);
      run_to_end(3, 2, "after_rst");

      // start_valid held high, inputs changed mid-job; next job accepted in first IDLE cycle
      mats_from_vec(0);
      load_mem(2, 2, tbl[0].sb, tbl[0].vb);
      mats_from_vec(1);
      load_mem(3, 2, tbl[1].sb, tbl[1].vb);
      exp_from_table(1);
      fork
         begin
            repeat (3) @(negedge clk);
            n_tokens = 16'd2; d_model = 16'd2;
            s_base = tbl[0].sb; v_base = tbl[0].vb; z_base = tbl[0].zb;
         end
      join_none
      start_job(3, 2, tbl[1].sb, tbl[1].vb, tbl[1].zb, 1'b1);
      run_to_end(3, 2, "hs_first");
      @(posedge clk); #1;
      start_valid = 1'b0;
      check("hs second_accept", ready, 1'b0);
      exp_from_table(0);
      run_to_end(2, 2, "hs_second");

      // Random jobs against the reference model
      for (int r = 0; r < 8; r++) begin
         int n, d;
         logic [15:0] zb;
         n  = $urandom_range(1, MAXN);
         d  = $urandom_range(1, MAXN);
         zb = 16'($urandom);
         for (int i = 0; i < MAXN; i++)
            for (int k = 0; k < MAXN; k++) begin
               s_mat[i][k] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 100);
               v_mat[i][k] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 100);
            end
         load_mem(n, d, 16'h4000, 16'h5000);
         build_expect(n, d, zb);
         start_job(n, d, 16'h4000, 16'h5000, zb, 1'b0);
         run_to_end(n, d, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/attention_value_stage.md
# attention_value_stage

Final stage of the self-attention datapath. It starts after the score stage has written S = Q·Kᵀ (N×N) into the result SRAM and V (N×D) into the scratchpad SRAM. It computes Z = S·V with one multiply-accumulate per cycle and writes Z row-major back into the result SRAM. It uses the same start/ready handshake and 1-cycle-latency SRAM read model as the upstream stages.

## Interface
Parameters:
- DIM_W, 16, width of the dimension ports and the internal i/j/k counters.
- DATA_W, 32, SRAM data width; must equal the `SRAM_DATA_RANGE` width.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request; accepted only while ready=1.
- ready  out  1  block idle; reset value 1.
- done  out  1  one-cycle pulse at job end; reset value 0.
- n_tokens  in  DIM_W  N; sampled on accept.
- d_model  in  DIM_W  D; sampled on accept.
- s_base, v_base, z_base  in  `SRAM_ADDR_RANGE`  base addresses of S (result SRAM), V (scratchpad SRAM) and Z (result SRAM); sampled on accept.
- dut__tb__sram_result_read_address  out  `SRAM_ADDR_RANGE`  S read address; reset value 0.
- tb__dut__sram_result_read_data  in  `SRAM_DATA_RANGE`  S data, valid 1 cycle after its address.
- dut__tb__sram_scratchpad_read_address  out  `SRAM_ADDR_RANGE`  V read address; reset value 0.
- tb__dut__sram_scratchpad_read_data  in  `SRAM_DATA_RANGE`  V data, valid 1 cycle after its address.
- dut__tb__sram_result_write_enable  out  1  Z write strobe; reset value 0.
- dut__tb__sram_result_write_address  out  `SRAM_ADDR_RANGE`  Z address; reset value 0.
- dut__tb__sram_result_write_data  out  `SRAM_DATA_RANGE`  Z data; reset value 0.

## Operation
- Z[i][j] = Σ_{k<N} S[i][k]·V[k][j].
- Addresses:
  - S[i][k] is read at s_base + i·N + k.
  - V[k][j] is read at v_base + k·D + j.
  - Z[i][j] is written at z_base + i·D + j.
  - All address arithmetic wraps modulo the address width.
- Output order: row-major, i outer, j inner, k innermost.
- Arithmetic: unsigned. Each product is reduced mod 2^DATA_W and the accumulator wraps mod 2^DATA_W (unless the macro in Configuration is defined).
- FSM states:
  - IDLE: ready=1. start_valid=1 latches the dims and bases, clears i/j/k and the accumulator, and moves to ISSUE. If N=0 or D=0 it moves to DONE instead.
  - ISSUE: presents the S/V addresses for the current k and increments k. Data returned in a cycle is accumulated in the following cycle through a 1-deep valid pipe. After k=N−1 it moves to DRAIN.
  - DRAIN: accumulates the last product. Goes to WRITE.
  - WRITE: write_enable=1 with address/data for Z[i][j]. Clears the accumulator and advances j (then i). If elements remain, goes to ISSUE; otherwise goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start_valid while ready=0 is ignored; no queueing.
- Input ports are not sampled outside the accept cycle; changes mid-job have no effect.
- Read addresses hold their last value outside ISSUE.
- Write address/data hold their last value when write_enable=0.

## Timing
- Accept happens on the edge where start_valid=1 and ready=1. ready falls in the following cycle.
- Each Z element costs N+2 cycles (N ISSUE, 1 DRAIN, 1 WRITE).
- ready returns exactly N·D·(N+2)+1 cycles after the accept edge; done is high in the cycle before.
- Degenerate N=0 or D=0: no reads, no writes; done in the cycle after accept, ready the cycle after that.
- Back-to-back jobs: a new job can be accepted in the first IDLE cycle.
- Reset: reset_n low at any time, including mid-job, forces IDLE immediately (asynchronously) and drives all outputs to their reset values. No partial write may follow.

## Configuration
- ATTN_SATURATE_EN
  - Defined: full 2·DATA_W-bit products; the accumulator clamps at 2^DATA_W−1 and stays there for the rest of that element.
  - Undefined: wrap-around as described in Operation.

## Structure
- Shared package attn_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN, WRITE, DONE);
  - DIM_W/DATA_W constants;
  - the all-ones saturation constant.
- One sub-module, attn_mac: accumulator with clear, enable and optional saturation. The address counters and FSM stay in attention_value_stage.

## Test plan
- Identity test: N=2, D=2, S=identity, V=[1,2;3,4].
  - Z=[1,2;3,4] at z_base..z_base+3.
  - Exactly 4 write strobes.
  - ready returns 17 cycles after accept.
- General test: N=3, D=2, S=[1,2,3;4,5,6;7,8,9], V=[1,0;0,1;1,1].
  - Z=[4,5;10,11;16,17], in row-major order.
- Overflow test: N=2, D=1, S row=[0xFFFF_FFFF,2], V=[1;1].
  - Macro undefined: Z=1.
  - ATTN_SATURATE_EN defined: Z=0xFFFF_FFFF.
- Degenerate test: n_tokens=0.
  - No reads and no writes.
  - done pulses 1 cycle after accept; ready is high 2 cycles after accept.
- Reset test: reset_n asserted during the 3rd ISSUE cycle of the N=3 job.
  - Immediately: write_enable=0, ready=1, done=0.
  - Restarting the job produces the correct full Z.
- Handshake test: start_valid held high through a whole job while the dims change mid-job.
  - Results use only the sampled dims.
  - A second job is accepted in the first IDLE cycle.
